// File: rtl/paddle_pkg.sv
// Shared types and default sizing for the paddle scan controller.
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUMP    = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int COUNT_W_DEF    = 8;
  localparam int MAX_COUNT_DEF  = 255;
  localparam int DUMP_LINES_DEF = 8;

endpackage

// File: rtl/paddle_sync.sv
// Two-flop synchroniser for one asynchronous comparator input.
module paddle_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Shift the raw pin through two flops before anyone looks at it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/paddle_scan_ctrl.sv
// Frame-synchronous paddle timer: dumps the RC caps, counts scanlines until
// each comparator rises, and publishes both positions at the next frame tick.
module paddle_scan_ctrl
  import paddle_pkg::*;
#(
  parameter int COUNT_W    = COUNT_W_DEF,
  parameter int MAX_COUNT  = MAX_COUNT_DEF,
  parameter int DUMP_LINES = DUMP_LINES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               hpaddle,
  input  logic               vpaddle,
  output logic               paddle_dump,
  output logic [COUNT_W-1:0] paddle_x,
  output logic [COUNT_W-1:0] paddle_y,
  output logic               pos_valid,
  output logic               x_timeout,
  output logic               y_timeout
);

  localparam int DW = $clog2(DUMP_LINES + 1);
  localparam logic [DW-1:0]      DUMP_LAST = DW'(DUMP_LINES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = COUNT_W'(MAX_COUNT);

  state_e             state_q, state_d;
  logic               hsync_q, vsync_q;
  logic [DW-1:0]      dump_cnt_q, dump_cnt_d;
  logic [COUNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [COUNT_W-1:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic               flag_x_q, flag_x_d, flag_y_q, flag_y_d;
  logic [COUNT_W-1:0] px_q, px_d, py_q, py_d;
  logic               xto_q, xto_d, yto_q, yto_d;
  logic               vld_q, vld_d;
  logic               hp_s, vp_s;
  logic               line_tick, frame_tick;

  paddle_sync u_sync_h (.clk(clk), .reset(reset), .d_i(hpaddle), .q_o(hp_s));
  paddle_sync u_sync_v (.clk(clk), .reset(reset), .d_i(vpaddle), .q_o(vp_s));

  // Sync inputs already live in clk; only the previous level is kept for edges.
  assign line_tick  = hsync & ~hsync_q;
  assign frame_tick = vsync & ~vsync_q;

  // State, counters, captures and published outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      dump_cnt_q <= '0;
      line_cnt_q <= '0;
      cap_x_q    <= '0;
      cap_y_q    <= '0;
      flag_x_q   <= 1'b0;
      flag_y_q   <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      xto_q      <= 1'b0;
      yto_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hsync_q    <= hsync;
      vsync_q    <= vsync;
      dump_cnt_q <= dump_cnt_d;
      line_cnt_q <= line_cnt_d;
      cap_x_q    <= cap_x_d;
      cap_y_q    <= cap_y_d;
      flag_x_q   <= flag_x_d;
      flag_y_q   <= flag_y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      xto_q      <= xto_d;
      yto_q      <= yto_d;
      vld_q      <= vld_d;
    end
  end

  // Next-state logic: frame tick dominates any same-cycle line tick.
  always_comb begin
    state_d    = state_q;
    dump_cnt_d = dump_cnt_q;
    line_cnt_d = line_cnt_q;
    cap_x_d    = cap_x_q;
    cap_y_d    = cap_y_q;
    flag_x_d   = flag_x_q;
    flag_y_d   = flag_y_q;
    px_d       = px_q;
    py_d       = py_q;
    xto_d      = xto_q;
    yto_d      = yto_q;
    vld_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d    = DUMP;
          dump_cnt_d = '0;
        end
      end
      DUMP: begin
        if (frame_tick) begin
          dump_cnt_d = '0;
        end else if (line_tick) begin
          if (dump_cnt_q == DUMP_LAST) begin
            state_d    = MEASURE;
            line_cnt_d = '0;
            flag_x_d   = 1'b0;
            flag_y_d   = 1'b0;
          end else begin
            dump_cnt_d = dump_cnt_q + 1'b1;
          end
        end
      end
      MEASURE: begin
        // Level capture of the pre-increment count; first high wins.
        if (hp_s && !flag_x_q) begin
          cap_x_d  = line_cnt_q;
          flag_x_d = 1'b1;
        end
        if (vp_s && !flag_y_q) begin
          cap_y_d  = line_cnt_q;
          flag_y_d = 1'b1;
        end
        if (frame_tick) begin
          px_d       = flag_x_q ? cap_x_q : CNT_MAX;
          py_d       = flag_y_q ? cap_y_q : CNT_MAX;
          xto_d      = ~flag_x_q;
          yto_d      = ~flag_y_q;
          vld_d      = 1'b1;
          state_d    = DUMP;
          dump_cnt_d = '0;
        end else if (line_tick && line_cnt_q != CNT_MAX) begin
          line_cnt_d = line_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign paddle_dump = (state_q != MEASURE);
  assign paddle_x    = px_q;
  assign paddle_y    = py_q;
  assign pos_valid   = vld_q;
  assign x_timeout   = xto_q;
  assign y_timeout   = yto_q;

endmodule
